fib_arbiter: RTL and testbench

Sequences the router's single FIB table between its two clients: the PIT path, which issues interest-prefix lookups, and the data path, which installs prefixes learned from returning data. Grants the FIB to one client at a time, drives the FIB start/op/prefix/len command, waits for completion or timeout, and returns a one-cycle response to the granted client. PIT requests have priority; a starvation counter bounds the data path's wait.

---
 rtl/ndn_pkg.sv | 7 +
 rtl/fib_arbiter_if.sv | 33 +++
 rtl/fib_arb_grant.sv | 27 ++
 rtl/fib_arbiter.sv | 120 ++++++++++++
 tb/tb_fib_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/ndn_pkg.sv
// ndn_pkg: shared widths, FIB opcode encoding and arbiter state encoding
package ndn_pkg;
    localparam int PREFIX_W = 64;
    localparam int LEN_W = 6;
    typedef enum logic {FIB_LOOKUP = 1'b0, FIB_INSERT = 1'b1} fib_op_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;
endpackage

// File: rtl/fib_arbiter_if.sv
// fib_arbiter_if: PIT client, data client and FIB command/response signals
interface fib_arbiter_if #(
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W = ndn_pkg::LEN_W
);
    logic pit_req;
    logic [PREFIX_W-1:0] pit_prefix;
    logic [LEN_W-1:0] pit_len;
    logic pit_rsp_valid;
    logic pit_rsp_hit;
    logic pit_rsp_err;
    logic data_req;
    logic [PREFIX_W-1:0] data_prefix;
    logic [LEN_W-1:0] data_len;
    logic data_ack;
    logic data_err;
    logic fib_start;
    logic fib_op;
    logic [PREFIX_W-1:0] fib_prefix;
    logic [LEN_W-1:0] fib_len;
    logic fib_done;
    logic fib_hit;
    modport slave (
        input pit_req, pit_prefix, pit_len, data_req, data_prefix, data_len, fib_done, fib_hit,
        output pit_rsp_valid, pit_rsp_hit, pit_rsp_err, data_ack, data_err,
        output fib_start, fib_op, fib_prefix, fib_len
    );
    modport master (
        output pit_req, pit_prefix, pit_len, data_req, data_prefix, data_len, fib_done, fib_hit,
        input pit_rsp_valid, pit_rsp_hit, pit_rsp_err, data_ack, data_err,
        input fib_start, fib_op, fib_prefix, fib_len
    );
endinterface

// File: rtl/fib_arb_grant.sv
// fib_arb_grant: PIT-priority grant decision with a saturating data starvation counter
module fib_arb_grant #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic grant,
    input  logic pit_req,
    input  logic data_req,
    output logic grant_data
);
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_STARVE);
    logic [SW-1:0] starve_q, starve_d;
    assign grant_data = data_req && (!pit_req || starve_q == SMAX);
    // count PIT grants that pass over a pending data request; forget them once data is served or gone
    always_comb begin
        starve_d = ((grant && grant_data) || (idle && !data_req)) ? '0 :
                   (grant && data_req && starve_q != SMAX) ? starve_q + 1'b1 : starve_q;
    end
    // starvation counter register
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else starve_q <= starve_d;
    end
endmodule

// File: rtl/fib_arbiter.sv
// fib_arbiter: grants the single FIB table to the PIT or data client and returns one-cycle responses
module fib_arbiter
    import ndn_pkg::*;
#(
    parameter int PREFIX_W = ndn_pkg::PREFIX_W,
    parameter int LEN_W = ndn_pkg::LEN_W,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    fib_arbiter_if.slave bus
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);
    arb_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic owner_q, owner_d;
    fib_op_e fib_op_q, fib_op_d;
    logic [PREFIX_W-1:0] fib_prefix_q, fib_prefix_d;
    logic [LEN_W-1:0] fib_len_q, fib_len_d;
    logic fib_start_q, fib_start_d;
    logic pit_rsp_valid_q, pit_rsp_valid_d;
    logic pit_rsp_hit_q, pit_rsp_hit_d;
    logic pit_rsp_err_q, pit_rsp_err_d;
    logic data_ack_q, data_ack_d;
    logic data_err_q, data_err_d;
    logic idle, grant, grant_data, finish;
    assign idle = state_q == IDLE;
    assign grant = idle && (bus.pit_req || bus.data_req);
    assign finish = bus.fib_done || cnt_q == TLAST;
    fib_arb_grant #(.MAX_STARVE(MAX_STARVE)) u_grant (
        .clk(clk),
        .rst(rst),
        .idle(idle),
        .grant(grant),
        .pit_req(bus.pit_req),
        .data_req(bus.data_req),
        .grant_data(grant_data)
    );
    // next-state, command latch and response pulses; every output is computed one cycle ahead
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        owner_d = owner_q;
        fib_op_d = fib_op_q;
        fib_prefix_d = fib_prefix_q;
        fib_len_d = fib_len_q;
        fib_start_d = 1'b0;
        pit_rsp_valid_d = 1'b0;
        pit_rsp_hit_d = 1'b0;
        pit_rsp_err_d = 1'b0;
        data_ack_d = 1'b0;
        data_err_d = 1'b0;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                fib_start_d = 1'b1;
                owner_d = grant_data;
                fib_op_d = grant_data ? FIB_INSERT : FIB_LOOKUP;
                fib_prefix_d = grant_data ? bus.data_prefix : bus.pit_prefix;
                fib_len_d = grant_data ? bus.data_len : bus.pit_len;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d = '0;
            end
            WAIT: if (finish) begin
                state_d = RESP;
                pit_rsp_valid_d = !owner_q;
                pit_rsp_hit_d = !owner_q && bus.fib_done && bus.fib_hit && fib_op_q == FIB_LOOKUP;
                pit_rsp_err_d = !owner_q && !bus.fib_done;
                data_ack_d = owner_q;
                data_err_d = owner_q && !bus.fib_done;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            owner_q <= 1'b0;
            fib_op_q <= FIB_LOOKUP;
            fib_prefix_q <= '0;
            fib_len_q <= '0;
            fib_start_q <= 1'b0;
            pit_rsp_valid_q <= 1'b0;
            pit_rsp_hit_q <= 1'b0;
            pit_rsp_err_q <= 1'b0;
            data_ack_q <= 1'b0;
            data_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            owner_q <= owner_d;
            fib_op_q <= fib_op_d;
            fib_prefix_q <= fib_prefix_d;
            fib_len_q <= fib_len_d;
            fib_start_q <= fib_start_d;
            pit_rsp_valid_q <= pit_rsp_valid_d;
            pit_rsp_hit_q <= pit_rsp_hit_d;
            pit_rsp_err_q <= pit_rsp_err_d;
            data_ack_q <= data_ack_d;
            data_err_q <= data_err_d;
        end
    end
    assign bus.fib_start = fib_start_q;
    assign bus.fib_op = fib_op_q;
    assign bus.fib_prefix = fib_prefix_q;
    assign bus.fib_len = fib_len_q;
    assign bus.pit_rsp_valid = pit_rsp_valid_q;
    assign bus.pit_rsp_hit = pit_rsp_hit_q;
    assign bus.pit_rsp_err = pit_rsp_err_q;
    assign bus.data_ack = data_ack_q;
    assign bus.data_err = data_err_q;
endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed cycle-accurate checks of grant order, latency, timeout and reset
module tb_fib_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    fib_arbiter_if #(.PREFIX_W(64), .LEN_W(6)) bus ();
    fib_arbiter #(.PREFIX_W(64), .LEN_W(6), .MAX_STARVE(4), .TIMEOUT(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_start(input string tag);
        int n = 0;
        while (!bus.fib_start && n < 20) begin
            step();
            n++;
        end
        check({tag, "_start"}, 64'(bus.fib_start), 64'd1);
    endtask
    task automatic check_idle_outs(input string tag);
        check({tag, "_start"}, 64'(bus.fib_start), 64'd0);
        check({tag, "_pvalid"}, 64'(bus.pit_rsp_valid), 64'd0);
        check({tag, "_dack"}, 64'(bus.data_ack), 64'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.pit_req = 1'b1;
        bus.pit_prefix = '1;
        bus.pit_len = '1;
        bus.data_req = 1'b1;
        bus.data_prefix = '1;
        bus.data_len = '1;
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        rst = 1'b1;
        step();
        step();
        check("rst_start", 64'(bus.fib_start), 64'd0);
        check("rst_op", 64'(bus.fib_op), 64'd0);
        check("rst_prefix", bus.fib_prefix, 64'd0);
        check("rst_len", 64'(bus.fib_len), 64'd0);
        check("rst_pvalid", 64'(bus.pit_rsp_valid), 64'd0);
        check("rst_phit", 64'(bus.pit_rsp_hit), 64'd0);
        check("rst_perr", 64'(bus.pit_rsp_err), 64'd0);
        check("rst_dack", 64'(bus.data_ack), 64'd0);
        check("rst_derr", 64'(bus.data_err), 64'd0);
        bus.pit_req = 1'b0;
        bus.data_req = 1'b0;
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        rst = 1'b0;
        step();
        check_idle_outs("post_rst");
        // PIT lookup with fib_done at cycle 3
        bus.pit_req = 1'b1;
        bus.pit_prefix = 64'h0000_0000_CAFE_F00D;
        bus.pit_len = 6'd32;
        step();
        check("lk_start", 64'(bus.fib_start), 64'd1);
        check("lk_op", 64'(bus.fib_op), 64'd0);
        check("lk_prefix", bus.fib_prefix, 64'h0000_0000_CAFE_F00D);
        check("lk_len", 64'(bus.fib_len), 64'd32);
        step();
        check("lk_start_once", 64'(bus.fib_start), 64'd0);
        step();
        check("lk_early_valid", 64'(bus.pit_rsp_valid), 64'd0);
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        step();
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        check("lk_valid", 64'(bus.pit_rsp_valid), 64'd1);
        check("lk_hit", 64'(bus.pit_rsp_hit), 64'd1);
        check("lk_err", 64'(bus.pit_rsp_err), 64'd0);
        check("lk_op_held", 64'(bus.fib_op), 64'd0);
        bus.pit_req = 1'b0;
        step();
        check_idle_outs("lk_after");
        // contention: PIT first, then the data insert
        bus.pit_req = 1'b1;
        bus.pit_prefix = 64'h1111_2222_3333_4444;
        bus.pit_len = 6'd24;
        bus.data_req = 1'b1;
        bus.data_prefix = 64'hDEAD_BEEF_0123_4567;
        bus.data_len = 6'd40;
        step();
        check("ct_p_start", 64'(bus.fib_start), 64'd1);
        check("ct_p_op", 64'(bus.fib_op), 64'd0);
        check("ct_p_prefix", bus.fib_prefix, 64'h1111_2222_3333_4444);
        step();
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b0;
        step();
        bus.fib_done = 1'b0;
        check("ct_p_valid", 64'(bus.pit_rsp_valid), 64'd1);
        check("ct_p_hit", 64'(bus.pit_rsp_hit), 64'd0);
        check("ct_p_dack", 64'(bus.data_ack), 64'd0);
        bus.pit_req = 1'b0;
        step();
        step();
        check("ct_d_start", 64'(bus.fib_start), 64'd1);
        check("ct_d_op", 64'(bus.fib_op), 64'd1);
        check("ct_d_prefix", bus.fib_prefix, 64'hDEAD_BEEF_0123_4567);
        check("ct_d_len", 64'(bus.fib_len), 64'd40);
        step();
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        step();
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        check("ct_d_ack", 64'(bus.data_ack), 64'd1);
        check("ct_d_err", 64'(bus.data_err), 64'd0);
        check("ct_d_pvalid", 64'(bus.pit_rsp_valid), 64'd0);
        bus.data_req = 1'b0;
        step();
        check_idle_outs("ct_after");
        // starvation: four PIT grants, one data grant, then PIT again
        bus.pit_req = 1'b1;
        bus.data_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_start($sformatf("sv%0d", i));
            check($sformatf("sv%0d_op", i), 64'(bus.fib_op), (i == 4) ? 64'd1 : 64'd0);
            step();
            bus.fib_done = 1'b1;
            step();
            bus.fib_done = 1'b0;
            check($sformatf("sv%0d_dack", i), 64'(bus.data_ack), (i == 4) ? 64'd1 : 64'd0);
            check($sformatf("sv%0d_pvalid", i), 64'(bus.pit_rsp_valid), (i == 4) ? 64'd0 : 64'd1);
            if (bus.data_ack) bus.data_req = 1'b0;
            step();
        end
        bus.pit_req = 1'b0;
        bus.data_req = 1'b0;
        step();
        // timeout: no fib_done, response at cycle 18, late done at cycle 20 ignored
        bus.pit_req = 1'b1;
        bus.pit_prefix = 64'h0000_0000_0BAD_CAFE;
        bus.pit_len = 6'd16;
        step();
        check("to_start", 64'(bus.fib_start), 64'd1);
        for (int k = 2; k <= 17; k++) step();
        check("to_c17_valid", 64'(bus.pit_rsp_valid), 64'd0);
        step();
        check("to_valid", 64'(bus.pit_rsp_valid), 64'd1);
        check("to_err", 64'(bus.pit_rsp_err), 64'd1);
        check("to_hit", 64'(bus.pit_rsp_hit), 64'd0);
        bus.pit_req = 1'b0;
        step();
        step();
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        step();
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        check_idle_outs("to_late");
        step();
        check_idle_outs("to_late2");
        // reset in WAIT of a data insert abandons it
        bus.data_req = 1'b1;
        bus.data_prefix = 64'h0F0F_0F0F_0F0F_0F0F;
        bus.data_len = 6'd12;
        step();
        check("rw_start", 64'(bus.fib_start), 64'd1);
        check("rw_op", 64'(bus.fib_op), 64'd1);
        step();
        rst = 1'b1;
        bus.data_req = 1'b0;
        step();
        rst = 1'b0;
        check("rw_op_rst", 64'(bus.fib_op), 64'd0);
        check("rw_prefix_rst", bus.fib_prefix, 64'd0);
        check("rw_dack_rst", 64'(bus.data_ack), 64'd0);
        step();
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        check("rw_dack_c4", 64'(bus.data_ack), 64'd0);
        step();
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        check_idle_outs("rw_late");
        check("rw_derr", 64'(bus.data_err), 64'd0);
        bus.pit_req = 1'b1;
        bus.pit_prefix = 64'h0000_0000_0000_ABCD;
        bus.pit_len = 6'd8;
        step();
        check("rw_p_start", 64'(bus.fib_start), 64'd1);
        check("rw_p_op", 64'(bus.fib_op), 64'd0);
        check("rw_p_prefix", bus.fib_prefix, 64'h0000_0000_0000_ABCD);
        step();
        bus.fib_done = 1'b1;
        bus.fib_hit = 1'b1;
        step();
        bus.fib_done = 1'b0;
        bus.fib_hit = 1'b0;
        check("rw_p_valid", 64'(bus.pit_rsp_valid), 64'd1);
        check("rw_p_hit", 64'(bus.pit_rsp_hit), 64'd1);
        check("rw_p_err", 64'(bus.pit_rsp_err), 64'd0);
        bus.pit_req = 1'b0;
        step();
        check_idle_outs("end");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
